key_debouncer: RTL and testbench
================================

KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000 (20 ms at 50 MHz), number of consecutive stable cycles required to accept a level change; legal range 2 to 2^24.
REQ-002 Port CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port key_n  input  1  raw pushbutton level, active-low (0 = pressed), asynchronous to CLOCK_50, may bounce.
REQ-005 Port pressed  output  1  debounced level, 1 = button held.
REQ-006 Port press_pulse  output  1  one-cycle strobe on each accepted press; drives the enable of the downstream 4-bit press counter.
REQ-007 Port release_pulse  output  1  one-cycle strobe on each accepted release.

Function
REQ-008 key_n SHALL pass through a two-flop synchronizer before any other logic; the synchronized value is key_s.
REQ-009 The FSM SHALL have exactly four states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-010 RELEASED: key_s = 0 -> PRESS_WAIT with stability counter cleared to 0; otherwise stay.
REQ-011 PRESS_WAIT: key_s = 1 -> RELEASED (bounce rejected, no pulse); key_s = 0 and counter = DEBOUNCE_CYCLES-1 -> PRESSED; otherwise counter increments by 1.
REQ-012 PRESSED: key_s = 1 -> RELEASE_WAIT with counter cleared to 0; otherwise stay.
REQ-013 RELEASE_WAIT: key_s = 0 -> PRESSED (bounce rejected, no pulse); key_s = 1 and counter = DEBOUNCE_CYCLES-1 -> RELEASED; otherwise counter increments.
REQ-014 pressed SHALL be 1 exactly when the state is PRESSED or RELEASE_WAIT, and SHALL be registered.
REQ-015 press_pulse SHALL be high for exactly the one cycle following the PRESS_WAIT -> PRESSED transition; release_pulse likewise for RELEASE_WAIT -> RELEASED.
REQ-016 Latency: key_n held low from rising edge 1 onward SHALL raise pressed and press_pulse after rising edge DEBOUNCE_CYCLES+3; release latency SHALL be identical.
REQ-017 Counter width SHALL be ceil(log2(DEBOUNCE_CYCLES)); the counter SHALL never wrap and SHALL hold when not in a WAIT state.
REQ-018 A key_n excursion shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no pulse and no change of pressed.
REQ-019 press_pulse and release_pulse SHALL never be high in the same cycle; at most one pulse per accepted transition, none while the button is held.

Reset
REQ-020 While reset = 1: state = RELEASED, counter = 0, both synchronizer flops = 1, pressed = 0, press_pulse = 0, release_pulse = 0, independent of CLOCK_50.
REQ-021 Reset asserted mid-WAIT or mid-PRESSED SHALL discard progress with no pulse emitted; after deassertion with key_n held low, a full debounce (REQ-016) SHALL occur before press_pulse.

Structure
REQ-022 Package key_debounce_pkg SHALL hold the four-state encoding and the DEBOUNCE_CYCLES default constant.
REQ-023 The synchronizer SHALL be the sub-module sync_2ff (1-bit, reset value parameterized, here 1); the FSM, counter and output registers stay in key_debouncer.

Verification (DEBOUNCE_CYCLES = 4)
REQ-024 Clean press: reset, key_n 1 -> 0 held -> pressed and press_pulse rise after edge 7, press_pulse low at edge 8, pressed stays 1.
REQ-025 Bounce: key_n low 2 cycles, high 1, low 2, high -> press_pulse never asserts, pressed stays 0.
REQ-026 Bounce then settle: key_n 0,1,0,1 on successive cycles, then 0 held -> exactly one press_pulse, 7 edges after the final falling edge.
REQ-027 Release: from PRESSED, key_n -> 1 held -> release_pulse one cycle after edge 7, pressed falls at the same edge.
REQ-028 Reset mid-PRESS_WAIT: key_n low, reset pulse at edge 4, key_n still low -> no pulse until 7 edges after reset deasserts.
REQ-029 Held button: key_n low for 100 cycles -> exactly one press_pulse, no release_pulse.

Source files
------------

// File: rtl/key_debounce_pkg.sv
// Shared definitions for the pushbutton debouncer: FSM state encoding and
// the default stability window.
package key_debounce_pkg;

  // 20 ms at 50 MHz
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000000;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  // The debounced level stays high until a release has been fully accepted.
  function automatic logic is_held(input key_state_e s);
    return (s == PRESSED) || (s == RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/key_debouncer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; both flops reset
// to RESET_VALUE so the output never shows a false edge after reset.
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_debouncer.sv
// Active-low pushbutton debouncer: a level change is accepted only after the
// synchronized input has stayed at the new level for DEBOUNCE_CYCLES cycles.
module key_debouncer
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic key_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  key_state_e       state;
  key_state_e       state_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             key_s;

  // Idle level of key_n is 1, so the synchronizer resets to 1.
  sync_2ff #(
    .RESET_VALUE(1'b1)
  ) u_sync (
    .clock(CLOCK_50),
    .reset(reset),
    .d    (key_n),
    .q    (key_s)
  );

  // Outputs are registered from the next state so they change on the same
  // edge as the accepting transition.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state         <= RELEASED;
      count         <= '0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_next;
      count         <= count_next;
      pressed       <= is_held(state_next);
      press_pulse   <= (state == PRESS_WAIT) && (state_next == PRESSED);
      release_pulse <= (state == RELEASE_WAIT) && (state_next == RELEASED);
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      RELEASED: begin
        if (!key_s) begin
          state_next = PRESS_WAIT;
          count_next = '0;
        end
      end
      PRESS_WAIT: begin
        if (key_s) begin
          state_next = RELEASED;
        end else if (count == CNT_LAST) begin
          state_next = PRESSED;
        end else begin
          count_next = count + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (key_s) begin
          state_next = RELEASE_WAIT;
          count_next = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!key_s) begin
          state_next = PRESSED;
        end else if (count == CNT_LAST) begin
          state_next = RELEASED;
        end else begin
          count_next = count + CNT_W'(1);
        end
      end
      default: begin
        state_next = RELEASED;
      end
    endcase
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench for key_debouncer with a short debounce window: directed
// scenarios with hand-computed edge timing plus randomized bouncing input.
module tb_key_debouncer;

  localparam int N = 4;

  logic CLOCK_50 = 1'b0;
  logic reset;
  logic key_n;
  logic pressed;
  logic press_pulse;
  logic release_pulse;

  int checks = 0;
  int errors = 0;
  int press_seen = 0;
  int release_seen = 0;

  key_debouncer #(
    .DEBOUNCE_CYCLES(N)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .key_n        (key_n),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%b expected=%b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkCount(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Holds key_n at value for the given number of rising edges.
  task automatic applyStimulus(input logic value, input int cycles);
    repeat (cycles) begin
      @(negedge CLOCK_50);
      key_n = value;
    end
  endtask

  task automatic after_edge();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Reference: the FSM sees key_n delayed by two edges; a level change is
  // accepted once N+1 consecutive samples disagree with the debounced level.
  logic m_s1, m_s2, m_pressed, m_press, m_rel;
  int   m_run;

  always @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      m_s1      <= 1'b1;
      m_s2      <= 1'b1;
      m_pressed <= 1'b0;
      m_press   <= 1'b0;
      m_rel     <= 1'b0;
      m_run     <= 0;
    end else begin
      automatic int run_n = (m_s2 == m_pressed) ? m_run + 1 : 0;
      m_s1    <= key_n;
      m_s2    <= m_s1;
      m_press <= 1'b0;
      m_rel   <= 1'b0;
      if (run_n == N + 1) begin
        m_pressed <= !m_pressed;
        m_press   <= !m_pressed;
        m_rel     <= m_pressed;
        m_run     <= 0;
      end else begin
        m_run <= run_n;
      end
    end
  end

  always @(posedge CLOCK_50) begin
    #1;
    checkOutput("model_pressed", pressed, m_pressed);
    checkOutput("model_press_pulse", press_pulse, m_press);
    checkOutput("model_release_pulse", release_pulse, m_rel);
    if (press_pulse) press_seen++;
    if (release_pulse) release_seen++;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int p0;
    int r0;
    reset = 1'b0;
    key_n = 1'b1;
    #1 reset = 1'b1;
    #2;
    checkOutput("reset_pressed", pressed, 1'b0);
    checkOutput("reset_press_pulse", press_pulse, 1'b0);
    checkOutput("reset_release_pulse", release_pulse, 1'b0);
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    applyStimulus(1'b1, 3);

    // Clean press: accepted at edge N+3 after key_n falls
    @(negedge CLOCK_50);
    key_n = 1'b0;
    repeat (6) @(posedge CLOCK_50);
    #1;
    checkOutput("press_edge6_pressed", pressed, 1'b0);
    checkOutput("press_edge6_pulse", press_pulse, 1'b0);
    after_edge();
    checkOutput("press_edge7_pressed", pressed, 1'b1);
    checkOutput("press_edge7_pulse", press_pulse, 1'b1);
    after_edge();
    checkOutput("press_edge8_pulse", press_pulse, 1'b0);
    checkOutput("press_edge8_pressed", pressed, 1'b1);

    // Release with identical latency
    @(negedge CLOCK_50);
    key_n = 1'b1;
    repeat (6) @(posedge CLOCK_50);
    #1;
    checkOutput("release_edge6_pressed", pressed, 1'b1);
    checkOutput("release_edge6_pulse", release_pulse, 1'b0);
    after_edge();
    checkOutput("release_edge7_pressed", pressed, 1'b0);
    checkOutput("release_edge7_pulse", release_pulse, 1'b1);
    after_edge();
    checkOutput("release_edge8_pulse", release_pulse, 1'b0);

    // Short bounces are rejected
    @(negedge CLOCK_50);
    p0 = press_seen;
    applyStimulus(1'b0, 2);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 2);
    applyStimulus(1'b1, 12);
    checkCount("bounce_press_count", press_seen - p0, 0);
    checkOutput("bounce_pressed", pressed, 1'b0);

    // Bounce then settle: one pulse, 7 edges after the final falling edge
    p0 = press_seen;
    applyStimulus(1'b0, 1);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 1);
    applyStimulus(1'b1, 1);
    @(negedge CLOCK_50);
    key_n = 1'b0;
    repeat (6) @(posedge CLOCK_50);
    #1;
    checkOutput("settle_edge6_pulse", press_pulse, 1'b0);
    after_edge();
    checkOutput("settle_edge7_pulse", press_pulse, 1'b1);
    applyStimulus(1'b0, 5);
    checkCount("settle_press_count", press_seen - p0, 1);
    applyStimulus(1'b1, 12);

    // Reset in the middle of a press wait discards progress
    @(negedge CLOCK_50);
    key_n = 1'b0;
    repeat (4) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b1;
    #1;
    checkOutput("rst_wait_pressed", pressed, 1'b0);
    checkOutput("rst_wait_pulse", press_pulse, 1'b0);
    @(negedge CLOCK_50);
    reset = 1'b0;
    repeat (6) @(posedge CLOCK_50);
    #1;
    checkOutput("rst_edge6_pulse", press_pulse, 1'b0);
    after_edge();
    checkOutput("rst_edge7_pulse", press_pulse, 1'b1);
    checkOutput("rst_edge7_pressed", pressed, 1'b1);

    // Reset while pressed clears the level without a release pulse
    @(negedge CLOCK_50);
    reset = 1'b1;
    #1;
    checkOutput("rst_pressed_level", pressed, 1'b0);
    checkOutput("rst_pressed_release", release_pulse, 1'b0);
    @(negedge CLOCK_50);
    reset = 1'b0;
    applyStimulus(1'b0, 10);
    applyStimulus(1'b1, 15);

    // Long hold: exactly one press pulse
    p0 = press_seen;
    r0 = release_seen;
    applyStimulus(1'b0, 100);
    checkCount("held_press_count", press_seen - p0, 1);
    checkCount("held_release_count", release_seen - r0, 0);
    checkOutput("held_pressed", pressed, 1'b1);
    applyStimulus(1'b1, 15);

    // Random bouncing with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
      end
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(1, 9)));
    end
    applyStimulus(1'b1, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
